key_expansion_inverse: RTL and testbench

KEY_EXPANSION_INVERSE -- requirements
Module: key_expansion_inverse

---
 rtl/key_expansion_inverse.sv | 162 ++++++++++++++++
 tb/tb_key_expansion_inverse.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_inverse.sv
// Inverse AES-128 key schedule: starting from the final round key, streams round keys
// NR down to 0 over a valid/ready handshake, one inverse schedule step per accepted key.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for start; last_key is sampled when start is seen
// S_EMIT | rk holds round key rk_round, advancing to the previous round on handshake

module key_expansion_inverse_sbox4 (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    // Forward AES S-box, entry 0 at the most significant byte.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word_o[b*8 +: 8] = SBOX[{word_i[b*8 +: 8], 3'b000} +: 8];
    end

endmodule

module key_expansion_inverse #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] last_key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk,
    output logic [3:0]   rk_round,
    output logic         done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [0:127] key_q, key_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         done_q, done_d;

    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot_p3, sub_p3;
    logic [7:0]   rcon_byte;
    logic [0:127] prev_key;
    logic         handshake;

    function automatic logic [7:0] rcon(input logic [3:0] c);
        logic [7:0] r;
        r = 8'h00;
        case (c)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // One inverse schedule step: recover w[i-4..i-1] from w[i..i+3].
    assign k0 = key_q[0:31];
    assign k1 = key_q[32:63];
    assign k2 = key_q[64:95];
    assign k3 = key_q[96:127];

    assign p3        = k3 ^ k2;
    assign p2        = k2 ^ k1;
    assign p1        = k1 ^ k0;
    assign rot_p3    = {p3[23:0], p3[31:24]};
    assign rcon_byte = rcon(cnt_q);

    key_expansion_inverse_sbox4 u_sbox (
        .word_i (rot_p3),
        .word_o (sub_p3)
    );

    assign p0        = k0 ^ sub_p3 ^ {rcon_byte, 24'h000000};
    assign prev_key  = {p0, p1, p2, p3};
    assign handshake = (state_q == S_EMIT) && rk_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = last_key;
                    cnt_d   = 4'(NR);
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (handshake) begin
                    if (cnt_q != 4'd0) begin
                        key_d = prev_key;
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        rk_valid = (state_q == S_EMIT);
        rk       = key_q;
        rk_round = cnt_q;
        done     = done_q;
    end

endmodule

// File: tb/tb_key_expansion_inverse.sv
// Bench for key_expansion_inverse: directed vector table plus hand-written corner sequences,
// with an independent forward AES-128 key expansion model as the reference schedule.
module tb_key_expansion_inverse;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] last_key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         done;

    key_expansion_inverse #(.NR(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .last_key (last_key),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_round (rk_round),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   tsbox [0:255];
    logic [127:0] sched [0:10];
    logic [127:0] cap_rk [0:15];
    logic [3:0]   cap_rd [0:15];
    int g_got, g_done, g_done_at, g_stable_err, g_done_bad;

    typedef struct {
        logic [127:0] key;
        bit           rand_ready;
        int           inject_at;
        bit           deep;
        logic [127:0] exp9;
        logic [127:0] exp1;
        logic [127:0] exp0;
    } vec_t;

    vec_t vecs [4];

    localparam logic [127:0] A1_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] A1_R9   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_R0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] Z_R9    = 128'h55636363000000000000000000000000;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a);
        return {a[6:0], a[7]};
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, s, r;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv;
            r = inv;
            for (int k = 0; k < 4; k++) begin
                r = rotl8(r);
                s = s ^ r;
            end
            tsbox[x] = s ^ 8'h63;
        end
    endtask

    task automatic expand_fwd(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tsbox[t[31:24]], tsbox[t[23:16]], tsbox[t[15:8]], tsbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called at a negedge right after start was accepted; returns at a negedge.
    task automatic collect(input bit rand_ready, input int inject_at, input bit stop_on_done,
                           input int budget);
        logic [127:0] hold_rk;
        logic [3:0]   hold_rd;
        bit           stalled;
        stalled = 1'b0;
        hold_rk = '0;
        hold_rd = '0;
        g_got = 0; g_done = 0; g_done_at = -1; g_stable_err = 0; g_done_bad = 0;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                g_done++;
                if (g_done_at < 0) g_done_at = c;
                if (busy || rk_valid) g_done_bad++;
                if (stop_on_done) break;
            end
            if (g_done_at >= 0 && c >= g_done_at + 3) break;
            if (stalled && !(rk_valid && rk == hold_rk && rk_round == hold_rd)) g_stable_err++;
            if (c == inject_at) begin
                start    = 1'b1;
                last_key = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
            end else begin
                start = 1'b0;
            end
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_valid && rk_ready) begin
                if (g_got < 16) begin
                    cap_rk[g_got] = rk;
                    cap_rd[g_got] = rk_round;
                end
                g_got++;
            end
            stalled = rk_valid && !rk_ready;
            hold_rk = rk;
            hold_rd = rk_round;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic launch(input logic [127:0] key, input string tag);
        @(negedge clk);
        start    = 1'b1;
        last_key = key;
        @(negedge clk);
        start    = 1'b0;
        last_key = ~key;
        chk($sformatf("%s first valid", tag), 128'(rk_valid), 128'd1);
        chk($sformatf("%s first round", tag), 128'(rk_round), 128'd10);
        chk($sformatf("%s first rk", tag), rk, key);
    endtask

    task automatic check_sequence(input string tag, input bit strict_timing);
        chk($sformatf("%s keys emitted", tag), 128'(g_got), 128'd11);
        chk($sformatf("%s done count", tag), 128'(g_done), 128'd1);
        chk($sformatf("%s stall stability", tag), 128'(g_stable_err), 128'd0);
        chk($sformatf("%s idle at done", tag), 128'(g_done_bad), 128'd0);
        if (strict_timing) chk($sformatf("%s done latency", tag), 128'(g_done_at), 128'd11);
        for (int j = 0; j < 11; j++)
            chk($sformatf("%s round idx %0d", tag, j), 128'(cap_rd[j]), 128'(10 - j));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b0;
        last_key = '0;
        build_sbox();

        vecs[0] = '{key: A1_LAST, rand_ready: 1'b0, inject_at: -1, deep: 1'b1,
                    exp9: A1_R9, exp1: A1_R1, exp0: A1_R0};
        vecs[1] = '{key: A1_LAST, rand_ready: 1'b1, inject_at: -1, deep: 1'b1,
                    exp9: A1_R9, exp1: A1_R1, exp0: A1_R0};
        vecs[2] = '{key: A1_LAST, rand_ready: 1'b1, inject_at: 4, deep: 1'b1,
                    exp9: A1_R9, exp1: A1_R1, exp0: A1_R0};
        vecs[3] = '{key: '0, rand_ready: 1'b0, inject_at: -1, deep: 1'b0,
                    exp9: Z_R9, exp1: '0, exp0: '0};

        repeat (3) @(negedge clk);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset rk_valid", 128'(rk_valid), 128'd0);
        chk("reset done", 128'(done), 128'd0);
        chk("reset rk", rk, 128'd0);
        chk("reset rk_round", 128'(rk_round), 128'd0);
        rst = 1'b0;

        // Directed vector table.
        for (int v = 0; v < 4; v++) begin
            launch(vecs[v].key, $sformatf("vec%0d", v));
            collect(vecs[v].rand_ready, vecs[v].inject_at, 1'b0, 300);
            check_sequence($sformatf("vec%0d", v), !vecs[v].rand_ready);
            chk($sformatf("vec%0d round10", v), cap_rk[0], vecs[v].key);
            chk($sformatf("vec%0d round9", v), cap_rk[1], vecs[v].exp9);
            if (vecs[v].deep) begin
                chk($sformatf("vec%0d round1", v), cap_rk[9], vecs[v].exp1);
                chk($sformatf("vec%0d round0", v), cap_rk[10], vecs[v].exp0);
                expand_fwd(vecs[v].exp0);
                for (int j = 0; j < 11; j++)
                    chk($sformatf("vec%0d model round %0d", v, 10 - j), cap_rk[j], sched[10 - j]);
            end
        end

        // Back-to-back: restart in the done cycle with an all-zero last key.
        launch(A1_LAST, "b2b first");
        collect(1'b0, -1, 1'b1, 100);
        chk("b2b first done latency", 128'(g_done_at), 128'd11);
        chk("b2b first round0", cap_rk[10], A1_R0);
        start    = 1'b1;
        last_key = '0;
        @(negedge clk);
        start    = 1'b0;
        last_key = A1_LAST;
        chk("b2b restart valid", 128'(rk_valid), 128'd1);
        chk("b2b restart round", 128'(rk_round), 128'd10);
        chk("b2b restart rk", rk, 128'd0);
        collect(1'b0, -1, 1'b0, 100);
        check_sequence("b2b second", 1'b1);
        chk("b2b second round9", cap_rk[1], Z_R9);

        // Reset in the middle of a run, concurrent with a handshake.
        launch(A1_LAST, "rstmid");
        begin
            bit found;
            found = 1'b0;
            rk_ready = 1'b1;
            for (int c = 0; c < 30; c++) begin
                if (rk_valid && rk_round == 4'd5) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("rstmid reached round 5", 128'(found), 128'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid busy", 128'(busy), 128'd0);
        chk("rstmid rk_valid", 128'(rk_valid), 128'd0);
        chk("rstmid done", 128'(done), 128'd0);
        chk("rstmid rk", rk, 128'd0);
        chk("rstmid rk_round", 128'(rk_round), 128'd0);
        @(negedge clk);
        chk("rstmid no late done", 128'(done), 128'd0);
        chk("rstmid still idle", 128'(busy), 128'd0);

        // Reset wins over a simultaneous start.
        rst      = 1'b1;
        start    = 1'b1;
        last_key = A1_LAST;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst over start busy", 128'(busy), 128'd0);

        launch(A1_LAST, "post rst");
        collect(1'b0, -1, 1'b0, 100);
        check_sequence("post rst", 1'b1);
        chk("post rst round0", cap_rk[10], A1_R0);

        // Round trip against the forward schedule for random cipher keys.
        for (int k = 0; k < 100; k++) begin
            logic [127:0] ck;
            ck = {$urandom, $urandom, $urandom, $urandom};
            expand_fwd(ck);
            launch(sched[10], $sformatf("rt%0d", k));
            collect(k[0], -1, 1'b0, 300);
            chk($sformatf("rt%0d keys emitted", k), 128'(g_got), 128'd11);
            chk($sformatf("rt%0d done count", k), 128'(g_done), 128'd1);
            chk($sformatf("rt%0d stall stability", k), 128'(g_stable_err), 128'd0);
            for (int j = 0; j < 11; j++)
                chk($sformatf("rt%0d round %0d", k, 10 - j), cap_rk[j], sched[10 - j]);
            chk($sformatf("rt%0d original key", k), cap_rk[10], ck);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
